channel_fifo_receiver: RTL and testbench



---
 rtl/channel_fifo_receiver.sv | 124 ++++++++++++
 tb/tb_channel_fifo_receiver.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_fifo_receiver.sv
// channel_fifo_receiver
//
// Receiving end of a valid/data-acknowledge Channel. Words offered by an
// upstream sender are buffered in a Depth-entry circular FIFO and offered
// again on a downstream Channel. This decouples producer and consumer timing
// while still moving one word per cycle on each side. A small monitor watches
// the upstream side and raises a sticky error if the sender withdraws or
// changes a word before it has been acknowledged.
//
// Ports:
//   clk    - clock, every state update happens on its rising edge
//   reset  - asynchronous, active-high reset
//   in_d   - upstream Channel data (N bits)
//   in_v   - upstream Channel valid
//   in_a   - upstream Channel acknowledge (combinational, never depends on out_a)
//   out_d  - downstream Channel data (N bits), head of the FIFO
//   out_v  - downstream Channel valid, high whenever the FIFO holds a word
//   out_a  - downstream Channel acknowledge from the consumer
//   count  - current occupancy, 0..Depth
//   err    - sticky upstream protocol-violation flag, cleared only by reset
//
// A word moves on a rising edge where both valid and acknowledge are high.
// There is no fall-through path, so a pushed word is visible on out_d one
// cycle after it is accepted.

module channel_fifo_receiver #(
  parameter int N     = 8,
  parameter int Depth = 4,
  parameter int CW    = $clog2(Depth + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  in_d,
  input  logic          in_v,
  output logic          in_a,
  output logic [N-1:0]  out_d,
  output logic          out_v,
  input  logic          out_a,
  output logic [CW-1:0] count,
  output logic          err
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr   = PtrW'(Depth - 1);
  localparam logic [CW-1:0]   FullCount = CW'(Depth);

  logic [N-1:0]    mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic            full;
  logic            push;
  logic            pop;
  logic            pend;
  logic [N-1:0]    pend_d;

  // Pointers walk 0..Depth-1 and wrap explicitly, so Depth does not have to
  // be a power of two.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  // Handshake decode. The upstream acknowledge only looks at our own
  // occupancy, never at out_a, so a full FIFO refuses a push even on an edge
  // where it also pops; the freed slot is offered on the following cycle.
  // Reset masks the acknowledge directly so nothing is accepted while it is
  // asserted. The downstream side is driven purely from registered state.
  assign full  = (count == FullCount);
  assign in_a  = ~reset & in_v & ~full;
  assign push  = in_v & in_a;
  assign out_v = (count != '0);
  assign pop   = out_v & out_a;
  assign out_d = mem[rd_ptr];

  // Storage array. It is deliberately left out of reset: the occupancy count
  // and pointers decide what is valid, so stale contents are never exposed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_d;
    end
  end

  // Read/write pointers and occupancy. A simultaneous push and pop advances
  // both pointers and leaves the count unchanged, which is what allows one
  // word per cycle with the count bouncing between 0 and 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Upstream protocol monitor. pend remembers that a word was offered but not
  // acknowledged on the previous edge, and pend_d remembers what that word
  // was. A legal sender must keep the same word valid until it is taken, so
  // dropping valid or changing the data while pending latches err. The
  // monitor only reports; it never alters how the FIFO handles the word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend   <= 1'b0;
      pend_d <= '0;
      err    <= 1'b0;
    end else begin
      pend   <= in_v & ~in_a;
      pend_d <= in_d;
      if (pend && (!in_v || (in_d != pend_d))) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_channel_fifo_receiver.sv
// Testbench for channel_fifo_receiver (N=8, Depth=4).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// before the next rising edge. The reference model is a plain queue holding
// the words the FIFO should contain, plus the pending-word rule for err.

module tb_channel_fifo_receiver;

  localparam int N     = 8;
  localparam int Depth = 4;
  localparam int CW    = $clog2(Depth + 1);

  logic          clk;
  logic          reset;
  logic [N-1:0]  in_d;
  logic          in_v;
  logic          in_a;
  logic [N-1:0]  out_d;
  logic          out_v;
  logic          out_a;
  logic [CW-1:0] count;
  logic          err;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] model_q[$];
  bit         model_pend;
  logic [7:0] model_pend_d;
  bit         model_err;
  bit         did_push;
  bit         did_pop;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       a;
    int         exp_count;
    logic       exp_in_a;
    logic       exp_out_v;
    logic [7:0] exp_out_d;
    logic       exp_err;
  } vec_t;

  vec_t vecs[13];

  channel_fifo_receiver #(.N(N), .Depth(Depth), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .in_d  (in_d),
    .in_v  (in_v),
    .in_a  (in_a),
    .out_d (out_d),
    .out_v (out_v),
    .out_a (out_a),
    .count (count),
    .err   (err)
  );

  // Free-running clock with rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports a miscompare on its own line.
  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Clears the reference model to the post-reset state.
  task automatic model_reset();
    model_q.delete();
    model_pend   = 1'b0;
    model_pend_d = '0;
    model_err    = 1'b0;
  endtask

  // Drives one cycle's inputs and lets combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic a);
    in_v  = v;
    in_d  = d;
    out_a = a;
    #1;
  endtask

  // Compares every DUT output with what the queue model says it should be.
  task automatic checkOutput(input string tag);
    int sz;
    sz = model_q.size();
    compare({tag, ".count"}, 32'(count), 32'(sz));
    compare({tag, ".in_a"},  32'(in_a),  32'(in_v && (sz < Depth)));
    compare({tag, ".out_v"}, 32'(out_v), 32'(sz != 0));
    if (sz != 0) begin
      compare({tag, ".out_d"}, 32'(out_d), 32'(model_q[0]));
    end
    compare({tag, ".err"},   32'(err),   32'(model_err));
  endtask

  // Waits for the next rising edge and applies the transfer rules to the model.
  task automatic advance();
    bit acc;
    bit take;
    @(posedge clk);
    acc  = (in_v === 1'b1) && (model_q.size() < Depth) && (reset === 1'b0);
    take = (out_a === 1'b1) && (model_q.size() != 0) && (reset === 1'b0);
    if (model_pend && (!in_v || (in_d != model_pend_d))) begin
      model_err = 1'b1;
    end
    model_pend   = in_v && !acc;
    model_pend_d = in_d;
    did_push = acc;
    did_pop  = take;
    if (take) begin
      void'(model_q.pop_front());
    end
    if (acc) begin
      model_q.push_back(in_d);
    end
    #1;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic a, input string tag);
    applyStimulus(v, d, a);
    checkOutput(tag);
    advance();
  endtask

  // Reset held across one rising edge, with the model cleared on release.
  task automatic pulse_reset();
    reset = 1'b1;
    in_v  = 1'b0;
    out_a = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int sent;
    int recvd;
    int cycles;
    int send_gap;
    int recv_gap;
    logic [7:0] cur;
    logic rv;
    logic ra;

    // Fill then stall: four words accepted, 0x55 held off, one pop frees a
    // slot that is only offered on the next cycle, then a data change while
    // pending sets err.
    vecs[0]  = '{1'b1, 8'h11, 1'b0, 0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 1, 1'b1, 1'b1, 8'h11, 1'b0};
    vecs[2]  = '{1'b1, 8'h33, 1'b0, 2, 1'b1, 1'b1, 8'h11, 1'b0};
    vecs[3]  = '{1'b1, 8'h44, 1'b0, 3, 1'b1, 1'b1, 8'h11, 1'b0};
    vecs[4]  = '{1'b1, 8'h55, 1'b0, 4, 1'b0, 1'b1, 8'h11, 1'b0};
    vecs[5]  = '{1'b1, 8'h55, 1'b0, 4, 1'b0, 1'b1, 8'h11, 1'b0};
    vecs[6]  = '{1'b1, 8'h55, 1'b1, 4, 1'b0, 1'b1, 8'h11, 1'b0};
    vecs[7]  = '{1'b1, 8'h55, 1'b0, 3, 1'b1, 1'b1, 8'h22, 1'b0};
    vecs[8]  = '{1'b0, 8'h55, 1'b0, 4, 1'b0, 1'b1, 8'h22, 1'b0};
    vecs[9]  = '{1'b1, 8'hAA, 1'b0, 4, 1'b0, 1'b1, 8'h22, 1'b0};
    vecs[10] = '{1'b1, 8'hAB, 1'b0, 4, 1'b0, 1'b1, 8'h22, 1'b0};
    vecs[11] = '{1'b0, 8'hAB, 1'b0, 4, 1'b0, 1'b1, 8'h22, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 4, 1'b0, 1'b1, 8'h22, 1'b1};

    reset = 1'b1;
    in_v  = 1'b1;
    in_d  = 8'h00;
    out_a = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] checking reset state");
    compare("reset.count", 32'(count), 32'(0));
    compare("reset.out_v", 32'(out_v), 32'(0));
    compare("reset.in_a",  32'(in_a),  32'(0));
    compare("reset.err",   32'(err),   32'(0));
    in_v  = 1'b0;
    reset = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].v, vecs[i].d, vecs[i].a);
      compare($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].exp_count));
      compare($sformatf("vec%0d.in_a", i),  32'(in_a),  32'(vecs[i].exp_in_a));
      compare($sformatf("vec%0d.out_v", i), 32'(out_v), 32'(vecs[i].exp_out_v));
      if (vecs[i].exp_out_v) begin
        compare($sformatf("vec%0d.out_d", i), 32'(out_d), 32'(vecs[i].exp_out_d));
      end
      compare($sformatf("vec%0d.err", i),   32'(err),   32'(vecs[i].exp_err));
      advance();
    end

    $display("[TB] mid-operation reset");
    step(1'b0, 8'h00, 1'b1, "pop_to3");
    compare("pre_rst.count", 32'(count), 32'(3));
    reset = 1'b1;
    in_v  = 1'b1;
    in_d  = 8'h99;
    out_a = 1'b0;
    #1;
    compare("rst_mid.count", 32'(count), 32'(0));
    compare("rst_mid.out_v", 32'(out_v), 32'(0));
    compare("rst_mid.in_a",  32'(in_a),  32'(0));
    compare("rst_mid.err",   32'(err),   32'(0));
    #3;
    reset = 1'b0;
    model_reset();
    step(1'b1, 8'h7E, 1'b0, "post_rst_push");
    compare("post_rst.out_d", 32'(out_d), 32'(8'h7E));
    step(1'b0, 8'h00, 1'b1, "post_rst_pop");
    step(1'b0, 8'h00, 1'b0, "post_rst_empty");

    $display("[TB] valid dropped while pending");
    for (int i = 0; i < Depth; i++) begin
      step(1'b1, 8'(8'h60 + i), 1'b0, "drop_fill");
    end
    step(1'b1, 8'hC3, 1'b0, "drop_hold");
    step(1'b0, 8'hC3, 1'b0, "drop_release");
    step(1'b0, 8'h00, 1'b0, "drop_after");
    compare("drop.err", 32'(err), 32'(1));
    pulse_reset();

    $display("[TB] full-rate stream");
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b1, "stream");
      compare("stream.count_le1", 32'(count <= CW'(1)), 32'(1));
    end
    step(1'b0, 8'h00, 1'b1, "stream_drain");
    step(1'b0, 8'h00, 1'b0, "stream_empty");

    $display("[TB] randomized traffic");
    sent     = 0;
    recvd    = 0;
    cycles   = 0;
    cur      = 8'($urandom);
    send_gap = $urandom_range(0, 5);
    recv_gap = $urandom_range(0, 5);
    while (recvd < 1000 && cycles < 20000) begin
      rv = (sent < 1000) && (send_gap == 0);
      ra = (recv_gap == 0);
      step(rv, cur, ra, "rand");
      compare("rand.count_range", 32'(count <= CW'(Depth)), 32'(1));
      cycles++;
      if (did_push) begin
        sent++;
        cur      = 8'($urandom);
        send_gap = $urandom_range(0, 5);
      end else if (send_gap > 0) begin
        send_gap--;
      end
      if (did_pop) begin
        recvd++;
        recv_gap = $urandom_range(0, 5);
      end else if (recv_gap > 0) begin
        recv_gap--;
      end
    end
    compare("rand.words_received", 32'(recvd), 32'(1000));
    compare("rand.final_count", 32'(count), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
